wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, sets the register data width.
REQ-002 Parameter LINK_REG, default 31, sets the register index written by link writes.
REQ-003 Port clk, input, 1, is the clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is a synchronous, active-high reset.
REQ-005 WB_data_mem  input  XLEN  writeback data from the MEM/WB register.
REQ-006 WB_rd  input  5  destination index for WB_data_mem.
REQ-007 WB_we  input  1  data write enable.
REQ-008 WB_link_addr  input  XLEN  return address to be written to LINK_REG.
REQ-009 WB_link_we  input  1  link write enable.
REQ-010 rs1_addr, rs2_addr  input  5 each  read port indices.
REQ-011 rs1_data, rs2_data  output  XLEN each  combinational read data.
REQ-012 wb_stall  output  1  registered; high means the upstream pipeline SHALL hold the MEM/WB register.

Function
REQ-013 The block SHALL hold a 32 x XLEN array with a single physical write port.
REQ-014 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-015 The FSM SHALL have exactly two states: IDLE and PEND.
- IDLE: wb_stall=0.
- PEND: wb_stall=1.
REQ-016 In IDLE, the following SHALL apply:
- WB_we only: write WB_data_mem to WB_rd.
- WB_link_we only: write WB_link_addr to LINK_REG.
- Neither: no write.
- In all of these cases the next state is IDLE.
REQ-017 In IDLE with WB_we and WB_link_we both high (collision), the block SHALL:
- write WB_data_mem to WB_rd this cycle;
- capture WB_link_addr in a 1-entry pending buffer;
- go to PEND.
REQ-018 In PEND, the block SHALL:
- write the pending value to LINK_REG;
- clear the pending buffer;
- ignore WB_we and WB_link_we;
- return to IDLE.
REQ-019 The write latency SHALL be 1 cycle for a non-collision write. For a collision, the link write SHALL land 1 cycle after the data write.
REQ-020 In a collision with WB_rd == LINK_REG, the final value of LINK_REG SHALL be WB_link_addr (the link write wins).
REQ-021 wb_stall SHALL be high for exactly one cycle per collision, and never for two consecutive cycles.
REQ-022 Read ports SHALL be fully combinational from rs*_addr, and index 0 SHALL read 0 regardless of bypass.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL:
- clear all 32 registers to 0;
- clear the pending buffer;
- set the state to IDLE;
- drive wb_stall to 0.
REQ-024 Write enables SHALL be ignored in any cycle where rst is high.
REQ-025 If rst is asserted while in PEND, the pending link write SHALL be discarded.
REQ-026 After reset, both read ports SHALL return 0 for every index until the first write.

Configuration
REQ-027 Macro WB_BYPASS_EN SHALL control write-to-read bypass.
REQ-028 With WB_BYPASS_EN defined, each read port SHALL return the value the register will hold after the current edge, using this priority:
- first, the current-cycle port write (in collision with WB_rd == LINK_REG, use WB_link_addr);
- second, the pending buffer value, for LINK_REG in PEND;
- third, the array.
REQ-029 With WB_BYPASS_EN undefined, reads SHALL return the array contents only. Writes SHALL become visible the cycle after the edge that performs them.

Verification
REQ-030 Reset, then read r0–r31 -> all 0 and wb_stall=0.
REQ-031 WB_we=1, WB_rd=5, WB_data_mem=0xDEADBEEF, rs1_addr=5, with the following results:
- next cycle: rs1_data=0xDEADBEEF;
- same cycle: 0xDEADBEEF with bypass, 0 without.
REQ-032 WB_we=1, WB_rd=0, data 0x1234 -> rs2_addr=0 reads 0 in all subsequent cycles.
REQ-033 Collision: WB_rd=7, data 0x11, WB_link_addr=0x400 produces the following:
- r7=0x11 after the first edge;
- wb_stall=1 for exactly one cycle;
- r31=0x400 after the second edge;
- WB_we asserted during the stall cycle is not written.
REQ-034 Collision with WB_rd=31, data 0xAA, WB_link_addr=0x800 produces the following:
- final r31=0x800;
- with bypass, rs1_addr=31 reads 0x800 in both the collision and PEND cycles.
REQ-035 Collision followed by rst in the PEND cycle produces the following:
- r31 stays 0;
- the state is IDLE;
- wb_stall=0 on the next cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: 32 x XLEN, single write port, link/data collision handled by a one-cycle stall.
// Optional feature: define WB_BYPASS_EN to forward the post-edge register value to the read ports.
module wb_regfile #(
  parameter int XLEN     = 32,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] WB_data_mem,
  input  logic [4:0]      WB_rd,
  input  logic            WB_we,
  input  logic [XLEN-1:0] WB_link_addr,
  input  logic            WB_link_we,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_stall
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] pend_data_p1;

  logic            collide;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;

  assign collide = (state == IDLE) && WB_we && WB_link_we;

  // Single write port arbitration: a pending link write owns the port in PEND,
  // otherwise the data write beats the link write, which is deferred on collision.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = 5'd0;
    wr_data = '0;
    if (!rst) begin
      if (state == PEND) begin
        wr_en   = 1'b1;
        wr_idx  = LINK_IDX;
        wr_data = pend_data_p1;
      end else if (WB_we) begin
        wr_en   = 1'b1;
        wr_idx  = WB_rd;
        wr_data = WB_data_mem;
      end else if (WB_link_we) begin
        wr_en   = 1'b1;
        wr_idx  = LINK_IDX;
        wr_data = WB_link_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      state        <= IDLE;
      wb_stall     <= 1'b0;
      pend_data_p1 <= '0;
    end else begin
      if (wr_en && (wr_idx != 5'd0)) begin
        regs[wr_idx] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (collide) begin
            state        <= PEND;
            wb_stall     <= 1'b1;
            pend_data_p1 <= WB_link_addr;
          end
        end
        PEND: begin
          state        <= IDLE;
          wb_stall     <= 1'b0;
          pend_data_p1 <= '0;
        end
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  logic            byp_en;
  logic [4:0]      byp_idx;
  logic [XLEN-1:0] byp_data;

  // On a collision into the link register the deferred link value is what survives.
  always_comb begin
    byp_en   = wr_en;
    byp_idx  = wr_idx;
    byp_data = wr_data;
    if (collide && !rst && (WB_rd == LINK_IDX)) begin
      byp_data = WB_link_addr;
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] arr_val,
    input logic            hit,
    input logic [XLEN-1:0] hit_val
  );
    return (addr == 5'd0) ? '0 : (hit ? hit_val : arr_val);
  endfunction

  assign rs1_data = read_port(rs1_addr, regs[rs1_addr], byp_en && (rs1_addr == byp_idx), byp_data);
  assign rs2_data = read_port(rs2_addr, regs[rs2_addr], byp_en && (rs2_addr == byp_idx), byp_data);
`else
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic against a queue-based model.
module tb_wb_regfile;

  localparam int XLEN     = 32;
  localparam int LINK_REG = 31;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] WB_data_mem;
  logic [4:0]      WB_rd;
  logic            WB_we;
  logic [XLEN-1:0] WB_link_addr;
  logic            WB_link_we;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_stall;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .LINK_REG(LINK_REG)) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_data_mem  (WB_data_mem),
    .WB_rd        (WB_rd),
    .WB_we        (WB_we),
    .WB_link_addr (WB_link_addr),
    .WB_link_we   (WB_link_we),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .wb_stall     (wb_stall)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Architectural view: register contents plus link writes accepted but not yet landed.
  logic [XLEN-1:0] mdl [32];
  logic [XLEN-1:0] nxt [32];
  logic [XLEN-1:0] pend_q [$];
  logic [XLEN-1:0] nxt_q [$];

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_next(input logic r, input logic we, input logic lwe,
                            input logic [4:0] rd, input logic [XLEN-1:0] d,
                            input logic [XLEN-1:0] la);
    nxt   = mdl;
    nxt_q = pend_q;
    if (r) begin
      foreach (nxt[i]) nxt[i] = '0;
      nxt_q.delete();
    end else if (pend_q.size() != 0) begin
      nxt[LINK_REG] = nxt_q.pop_front();
    end else begin
      if (we && rd != 5'd0) nxt[rd] = d;
      if (lwe) begin
        if (we) nxt_q.push_back(la);
        else    nxt[LINK_REG] = la;
      end
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a, input logic data_to_link);
    if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    // Value after the edge; a just-deferred link write overrides a same-cycle data write to the link register.
    if (int'(a) == LINK_REG && nxt_q.size() != 0 && pend_q.size() == 0 && data_to_link)
      return nxt_q[0];
    return nxt[a];
`else
    if (data_to_link) return mdl[a];
    return mdl[a];
`endif
  endfunction

  task automatic cycle(input logic r, input logic we, input logic lwe,
                       input logic [4:0] rd, input logic [XLEN-1:0] d,
                       input logic [XLEN-1:0] la, input logic [4:0] a1,
                       input logic [4:0] a2, input string tag);
    logic dl;
    rst          = r;
    WB_we        = we;
    WB_link_we   = lwe;
    WB_rd        = rd;
    WB_data_mem  = d;
    WB_link_addr = la;
    rs1_addr     = a1;
    rs2_addr     = a2;
    dl = we && (int'(rd) == LINK_REG);
    model_next(r, we, lwe, rd, d, la);
    #1;
    chk({tag, ".stall"}, XLEN'(wb_stall), XLEN'(pend_q.size() != 0));
    if (!r) begin
      chk({tag, ".rs1"}, rs1_data, exp_rd(a1, dl));
      chk({tag, ".rs2"}, rs2_data, exp_rd(a2, dl));
    end
    @(posedge clk);
    mdl    = nxt;
    pend_q = nxt_q;
    @(negedge clk);
  endtask

  task automatic peek(input logic [4:0] a, input logic [XLEN-1:0] e, input string tag);
    rst        = 1'b0;
    WB_we      = 1'b0;
    WB_link_we = 1'b0;
    rs1_addr   = a;
    #1;
    chk(tag, rs1_data, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; WB_we = 1'b0; WB_link_we = 1'b0; WB_rd = '0;
    WB_data_mem = '0; WB_link_addr = '0; rs1_addr = '0; rs2_addr = '0;
    foreach (mdl[i]) mdl[i] = '0;
    pend_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset.stall", XLEN'(wb_stall), '0);

    // All registers read zero after reset
    for (int i = 0; i < 32; i++)
      cycle(0, 0, 0, 5'd0, '0, '0, 5'(i), 5'(31 - i), "rst_read");

    // Plain write and read-after-write
    cycle(0, 1, 0, 5'd5, 32'hDEADBEEF, '0, 5'd5, 5'd5, "wr5");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd5, 5'd0, "rd5");
    peek(5'd5, 32'hDEADBEEF, "peek_r5");

    // Writes to r0 discarded
    cycle(0, 1, 0, 5'd0, 32'h1234, '0, 5'd5, 5'd0, "wr0");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd0, 5'd0, "rd0a");
    cycle(0, 0, 1, 5'd0, '0, 32'h0000_0100, 5'd31, 5'd0, "link_only");
    peek(5'd0, '0, "peek_r0");
    peek(5'd31, 32'h0000_0100, "peek_link_only");

    // Collision, with a data write attempted during the stall cycle
    cycle(0, 1, 1, 5'd7, 32'h11, 32'h400, 5'd7, 5'd31, "coll");
    cycle(0, 1, 1, 5'd9, 32'h55, 32'h777, 5'd7, 5'd31, "coll_pend");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd9, 5'd31, "coll_after");
    peek(5'd7, 32'h11, "peek_r7");
    peek(5'd31, 32'h400, "peek_r31");
    peek(5'd9, '0, "peek_r9");

    // Collision targeting the link register: link write wins
    cycle(0, 1, 1, 5'd31, 32'hAA, 32'h800, 5'd31, 5'd31, "coll31");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd31, 5'd31, "coll31_pend");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd31, 5'd0, "coll31_after");
    peek(5'd31, 32'h800, "peek_r31_link_wins");

    // Reset during the stall cycle drops the pending link write
    cycle(1, 0, 0, 5'd0, '0, '0, 5'd0, 5'd0, "rst2");
    cycle(0, 1, 1, 5'd3, 32'h33, 32'h999, 5'd3, 5'd31, "coll_rst");
    cycle(1, 1, 1, 5'd4, 32'h44, 32'h888, 5'd31, 5'd4, "pend_rst");
    cycle(0, 0, 0, 5'd0, '0, '0, 5'd31, 5'd3, "after_pend_rst");
    peek(5'd31, '0, "peek_r31_dropped");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic r, we, lwe;
      logic [4:0] rd, a1, a2;
      r   = ($urandom_range(0, 99) < 2);
      we  = ($urandom_range(0, 99) < 50);
      lwe = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      cycle(r, we, lwe, rd, XLEN'($urandom), XLEN'($urandom), a1, a2, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
